// File: rtl/jtkicker_gfx_arb_if.sv
// -----------------------------------------------------------------------------
// jtkicker_gfx_arb_if
// Bus bundle between the scroll/object graphics fetchers, the arbiter and the
// SDRAM graphics read slot.
//
// Modports:
//   master : arbiter side. Receives the client requests and returns the client
//            data/ok. Drives the SDRAM request and receives the SDRAM data/ok.
//   slave  : environment side (video layers plus SDRAM slot), the mirror image.
//
// Signals:
//   scr_cs/scr_addr -> scr_data/scr_ok   scroll tile client
//   obj_cs/obj_addr -> obj_data/obj_ok   object line client
//   sdram_cs/sdram_addr -> sdram_data/sdram_ok   shared SDRAM read port
// -----------------------------------------------------------------------------
interface jtkicker_gfx_arb_if #(
    parameter int SCR_AW   = 13,
    parameter int OBJ_AW   = 14,
    parameter int SDRAM_AW = 22
);
    logic                scr_cs;
    logic [SCR_AW-1:0]   scr_addr;
    logic [31:0]         scr_data;
    logic                scr_ok;

    logic                obj_cs;
    logic [OBJ_AW-1:0]   obj_addr;
    logic [31:0]         obj_data;
    logic                obj_ok;

    logic                sdram_cs;
    logic [SDRAM_AW-1:0] sdram_addr;
    logic [31:0]         sdram_data;
    logic                sdram_ok;

    modport master (
        input  scr_cs, scr_addr,
        output scr_data, scr_ok,
        input  obj_cs, obj_addr,
        output obj_data, obj_ok,
        output sdram_cs, sdram_addr,
        input  sdram_data, sdram_ok
    );

    modport slave (
        output scr_cs, scr_addr,
        input  scr_data, scr_ok,
        output obj_cs, obj_addr,
        input  obj_data, obj_ok,
        input  sdram_cs, sdram_addr,
        output sdram_data, sdram_ok
    );
endinterface

// File: rtl/jtkicker_gfx_arb.sv
// -----------------------------------------------------------------------------
// jtkicker_gfx_arb
// Shares one 32-bit SDRAM graphics read port between the scroll tile fetcher
// and the object line fetcher. Each client has a one-entry address/data cache,
// so a repeated address is answered locally. Scroll wins when only it waits or
// when objects were served last; objects win otherwise, so both clients
// waiting at once produces strict alternation.
//
// Ports:
//   rst  asynchronous, active-high reset
//   clk  system clock (48 MHz)
//   gfx  jtkicker_gfx_arb_if.master bundle (client requests/data, SDRAM port)
// -----------------------------------------------------------------------------
module jtkicker_gfx_arb #(
    parameter int                  SCR_AW     = 13,
    parameter int                  OBJ_AW     = 14,
    parameter int                  SDRAM_AW   = 22,
    parameter logic [SDRAM_AW-1:0] SCR_OFFSET = 22'h0,
    parameter logic [SDRAM_AW-1:0] OBJ_OFFSET = 22'h2000
) (
    input  logic                   rst,
    input  logic                   clk,
    jtkicker_gfx_arb_if.master     gfx
);

    localparam int ISS_W = (SCR_AW > OBJ_AW) ? SCR_AW : OBJ_AW;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SCR = 2'd1;
    localparam logic [1:0] ST_WAIT_OBJ = 2'd2;

    localparam logic GNT_SCR = 1'b0;
    localparam logic GNT_OBJ = 1'b1;

    // Client address to SDRAM address: modular add, wraps at SDRAM_AW bits.
    function automatic logic [SDRAM_AW-1:0] f_map(
        input logic [SDRAM_AW-1:0] offset,
        input logic [ISS_W-1:0]    addr
    );
        return offset + SDRAM_AW'(addr);
    endfunction

    logic [1:0]          r_state;
    logic                r_blank;
    logic                r_last_grant;
    logic [ISS_W-1:0]    r_issue_addr;
    logic                r_sdram_cs;
    logic [SDRAM_AW-1:0] r_sdram_addr;

    logic                r_scr_pend;
    logic                r_scr_valid;
    logic [SCR_AW-1:0]   r_scr_tag;
    logic [31:0]         r_scr_data;
    logic                r_scr_ok;

    logic                r_obj_pend;
    logic                r_obj_valid;
    logic [OBJ_AW-1:0]   r_obj_tag;
    logic [31:0]         r_obj_data;
    logic                r_obj_ok;

    logic w_scr_hit, w_scr_miss, w_obj_hit, w_obj_miss;
    logic w_done_scr, w_done_obj;
    logic w_idle, w_gnt_scr, w_gnt_obj;

    assign w_scr_hit  = gfx.scr_cs & r_scr_valid & (gfx.scr_addr == r_scr_tag);
    assign w_scr_miss = gfx.scr_cs & ~w_scr_hit;
    assign w_obj_hit  = gfx.obj_cs & r_obj_valid & (gfx.obj_addr == r_obj_tag);
    assign w_obj_miss = gfx.obj_cs & ~w_obj_hit;

    // The first WAIT cycle is blanked: the slot may still show the ok of the
    // previous transaction there.
    assign w_done_scr = (r_state == ST_WAIT_SCR) & ~r_blank & gfx.sdram_ok;
    assign w_done_obj = (r_state == ST_WAIT_OBJ) & ~r_blank & gfx.sdram_ok;

    // Both pending: serve whoever was not served last.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_gnt_scr = w_idle & r_scr_pend & (~r_obj_pend | (r_last_grant == GNT_OBJ));
    assign w_gnt_obj = w_idle & r_obj_pend & (~r_scr_pend | (r_last_grant == GNT_SCR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_blank      <= 1'b0;
            r_last_grant <= GNT_OBJ;
            r_issue_addr <= '0;
            r_sdram_cs   <= 1'b0;
            r_sdram_addr <= '0;
            r_scr_pend   <= 1'b0;
            r_scr_valid  <= 1'b0;
            r_scr_tag    <= '0;
            r_scr_data   <= '0;
            r_scr_ok     <= 1'b0;
            r_obj_pend   <= 1'b0;
            r_obj_valid  <= 1'b0;
            r_obj_tag    <= '0;
            r_obj_data   <= '0;
            r_obj_ok     <= 1'b0;
        end else begin
            r_scr_ok <= w_scr_hit;
            r_obj_ok <= w_obj_hit;
            // A completing client must not re-request on the miss it saw
            // against the cache contents from before the fill.
            r_scr_pend <= w_scr_miss & ~w_done_scr;
            r_obj_pend <= w_obj_miss & ~w_done_obj;

            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_scr) begin
                        r_issue_addr <= ISS_W'(gfx.scr_addr);
                        r_sdram_addr <= f_map(SCR_OFFSET, ISS_W'(gfx.scr_addr));
                        r_sdram_cs   <= 1'b1;
                        r_blank      <= 1'b1;
                        r_state      <= ST_WAIT_SCR;
                    end else if (w_gnt_obj) begin
                        r_issue_addr <= ISS_W'(gfx.obj_addr);
                        r_sdram_addr <= f_map(OBJ_OFFSET, ISS_W'(gfx.obj_addr));
                        r_sdram_cs   <= 1'b1;
                        r_blank      <= 1'b1;
                        r_state      <= ST_WAIT_OBJ;
                    end
                end
                ST_WAIT_SCR, ST_WAIT_OBJ: begin
                    if (r_blank) begin
                        r_blank <= 1'b0;
                    end else if (gfx.sdram_ok) begin
                        // Fill with the issued address even if the client has
                        // moved on; its ok then simply stays low.
                        r_sdram_cs <= 1'b0;
                        r_state    <= ST_IDLE;
                        if (r_state == ST_WAIT_SCR) begin
                            r_scr_tag    <= r_issue_addr[SCR_AW-1:0];
                            r_scr_data   <= gfx.sdram_data;
                            r_scr_valid  <= 1'b1;
                            r_last_grant <= GNT_SCR;
                        end else begin
                            r_obj_tag    <= r_issue_addr[OBJ_AW-1:0];
                            r_obj_data   <= gfx.sdram_data;
                            r_obj_valid  <= 1'b1;
                            r_last_grant <= GNT_OBJ;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gfx.scr_data   = r_scr_data;
    assign gfx.scr_ok     = r_scr_ok;
    assign gfx.obj_data   = r_obj_data;
    assign gfx.obj_ok     = r_obj_ok;
    assign gfx.sdram_cs   = r_sdram_cs;
    assign gfx.sdram_addr = r_sdram_addr;

endmodule

// File: tb/tb_jtkicker_gfx_arb.sv
module tb_jtkicker_gfx_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtkicker_gfx_arb_if #(.SCR_AW(13), .OBJ_AW(14), .SDRAM_AW(22)) bus ();
    jtkicker_gfx_arb_if #(.SCR_AW(13), .OBJ_AW(14), .SDRAM_AW(22)) bus_w ();

    jtkicker_gfx_arb #(
        .SCR_AW(13), .OBJ_AW(14), .SDRAM_AW(22),
        .SCR_OFFSET(22'h0), .OBJ_OFFSET(22'h2000)
    ) dut (
        .rst(rst), .clk(clk), .gfx(bus)
    );

    // Second instance only exercises the wrapping object offset.
    jtkicker_gfx_arb #(
        .SCR_AW(13), .OBJ_AW(14), .SDRAM_AW(22),
        .SCR_OFFSET(22'h0), .OBJ_OFFSET(22'h3FFFFF)
    ) dut_w (
        .rst(rst), .clk(clk), .gfx(bus_w)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem(input logic [21:0] a);
        return {a[9:0], a} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [21:0] base(input int c);
        return (c == 1) ? 22'h2000 : 22'h0;
    endfunction

    // reference model state for the random phase
    logic        r_cs[2];
    logic [13:0] r_addr[2];
    logic        m_valid[2];
    logic [13:0] m_tag[2];
    logic [31:0] m_data[2];
    logic        pend_prev[2];
    logic        pend_now[2];
    logic        hit_pre[2];
    int          starve[2];
    int          m_last, max_starve;
    logic        was_cs, done;
    int          dcli, cli, expc, cnt, lat, g_cli, ngr, extra;
    logic [21:0] g_addr;
    logic [12:0] pa_s;
    logic [13:0] pa_o;

    initial begin
        bus.scr_cs = 0; bus.scr_addr = '0; bus.obj_cs = 0; bus.obj_addr = '0;
        bus.sdram_ok = 0; bus.sdram_data = '0;
        bus_w.scr_cs = 0; bus_w.scr_addr = '0; bus_w.obj_cs = 0; bus_w.obj_addr = '0;
        bus_w.sdram_ok = 0; bus_w.sdram_data = '0;
        rst = 1;
        tick(2);
        chk("rst_sdram_cs", bus.sdram_cs, 0);
        chk("rst_sdram_addr", bus.sdram_addr, 0);
        chk("rst_scr_ok", bus.scr_ok, 0);
        chk("rst_obj_ok", bus.obj_ok, 0);
        chk("rst_scr_data", bus.scr_data, 0);
        chk("rst_obj_data", bus.obj_data, 0);
        rst = 0;

        // scroll miss, fill, then hit
        bus.scr_cs = 1; bus.scr_addr = 13'h0123;
        tick(1); chk("miss_lat_n", bus.sdram_cs, 0);
        tick(1); chk("miss_lat_n1", bus.sdram_cs, 1);
        chk("scr_sdram_addr", bus.sdram_addr, 22'h000123);
        tick(1); chk("scr_blank_cs", bus.sdram_cs, 1);
        bus.sdram_ok = 1; bus.sdram_data = 32'hDEADBEEF;
        tick(1); chk("scr_done_cs", bus.sdram_cs, 0);
        chk("scr_ok_early", bus.scr_ok, 0);
        bus.sdram_ok = 0; bus.sdram_data = '0;
        tick(1); chk("scr_ok", bus.scr_ok, 1);
        chk("scr_data", bus.scr_data, 32'hDEADBEEF);
        extra = 0;
        repeat (8) begin
            tick(1);
            if (bus.sdram_cs) extra++;
        end
        chk("scr_hold_no_req", extra, 0);
        chk("scr_hold_ok", bus.scr_ok, 1);

        // object offset, wrapped offset, permanently high ok
        bus.obj_cs = 1; bus.obj_addr = 14'h3FFF;
        bus_w.obj_cs = 1; bus_w.obj_addr = 14'h0001;
        tick(2);
        chk("obj_cs", bus.sdram_cs, 1);
        chk("obj_sdram_addr", bus.sdram_addr, 22'h005FFF);
        chk("wrap_cs", bus_w.sdram_cs, 1);
        chk("wrap_sdram_addr", bus_w.sdram_addr, 22'h000000);
        bus.sdram_ok = 1; bus.sdram_data = 32'h0BADF00D;
        tick(1); chk("stale_ok_ignored", bus.sdram_cs, 1);
        tick(1); chk("stale_ok_done", bus.sdram_cs, 0);
        chk("obj_data", bus.obj_data, 32'h0BADF00D);
        bus.sdram_ok = 0;
        tick(1); chk("obj_ok", bus.obj_ok, 1);
        chk("scr_ok_kept", bus.scr_ok, 1);

        // contention: both always missing, grants must alternate from SCR
        bus.scr_cs = 0; bus.obj_cs = 0;
        rst = 1; tick(1); rst = 0;
        bus.sdram_ok = 1; bus.sdram_data = 32'h12345678;
        bus.scr_cs = 1; bus.obj_cs = 1;
        bus.scr_addr = 13'h0100; bus.obj_addr = 14'h0200;
        was_cs = 0; ngr = 0;
        for (int i = 0; i < 24; i++) begin
            pa_s = bus.scr_addr; pa_o = bus.obj_addr;
            tick(1);
            if (bus.sdram_cs && !was_cs) begin
                cli = (bus.sdram_addr >= 22'h2000) ? 1 : 0;
                chk("cont_gnt_client", cli, ngr % 2);
                chk("cont_gnt_addr", bus.sdram_addr, (cli == 1) ? 22'h2000 + 22'(pa_o) : 22'(pa_s));
                ngr++;
            end
            was_cs = bus.sdram_cs;
            bus.scr_addr = 13'h0101 + 13'(i);
            bus.obj_addr = 14'h0201 + 14'(i);
        end
        chk("cont_enough_grants", ngr >= 4, 1);
        bus.scr_cs = 0; bus.obj_cs = 0;
        tick(6);
        bus.sdram_ok = 0;
        chk("cont_idle", bus.sdram_cs, 0);

        // scroll address change while its fetch is in flight
        bus.scr_cs = 1; bus.scr_addr = 13'd5;
        tick(2); chk("chg_cs", bus.sdram_cs, 1);
        chk("chg_addr5", bus.sdram_addr, 22'd5);
        bus.scr_addr = 13'd6;
        tick(1); bus.sdram_ok = 1; bus.sdram_data = 32'h55555555;
        tick(1); chk("chg_done", bus.sdram_cs, 0);
        chk("chg_ok_low", bus.scr_ok, 0);
        chk("chg_data", bus.scr_data, 32'h55555555);
        bus.sdram_ok = 0; bus.scr_addr = 13'd5;
        tick(1); chk("chg_tag_is_5", bus.scr_ok, 1);
        chk("chg_no_req_on_5", bus.sdram_cs, 0);
        bus.scr_addr = 13'd6;
        tick(1); chk("chg_ok_drop", bus.scr_ok, 0);
        tick(1); chk("chg_refetch_cs", bus.sdram_cs, 1);
        chk("chg_refetch_addr", bus.sdram_addr, 22'd6);
        tick(1); bus.sdram_ok = 1; bus.sdram_data = 32'h66666666;
        tick(1); bus.sdram_ok = 0;
        tick(1); chk("chg_ok6", bus.scr_ok, 1);
        chk("chg_data6", bus.scr_data, 32'h66666666);
        bus.scr_cs = 0;

        // reset during WAIT_OBJ
        bus.obj_cs = 1; bus.obj_addr = 14'h00AB;
        tick(2); chk("rstm_first_addr", bus.sdram_addr, 22'h0020AB);
        tick(1); bus.sdram_ok = 1; bus.sdram_data = 32'h000000AB;
        tick(1); bus.sdram_ok = 0;
        tick(1); chk("rstm_ok_before", bus.obj_ok, 1);
        bus.obj_addr = 14'h00AC;
        tick(2); chk("rstm_in_flight", bus.sdram_cs, 1);
        bus.obj_addr = 14'h00AB;
        tick(1); chk("rstm_hit_in_wait", bus.obj_ok, 1);
        #2 rst = 1;
        #1;
        chk("rstm_cs_now", bus.sdram_cs, 0);
        chk("rstm_ok_now", bus.obj_ok, 0);
        chk("rstm_data_now", bus.obj_data, 0);
        tick(1); rst = 0;
        tick(2); chk("rstm_refetch_cs", bus.sdram_cs, 1);
        chk("rstm_refetch_addr", bus.sdram_addr, 22'h0020AB);

        // randomized traffic against a transaction-level model
        bus.scr_cs = 0; bus.obj_cs = 0; bus.sdram_ok = 0;
        rst = 1; tick(1); rst = 0;
        for (int c = 0; c < 2; c++) begin
            r_cs[c] = 0; r_addr[c] = '0; m_valid[c] = 0; m_tag[c] = '0;
            m_data[c] = '0; pend_prev[c] = 0; starve[c] = 0;
        end
        bus.scr_addr = '0; bus.obj_addr = '0;
        m_last = 1; max_starve = 0; was_cs = 0; cnt = 0; lat = 1; g_cli = 0; g_addr = '0;
        for (int k = 0; k < 1500; k++) begin
            tick(1);
            done = 0; dcli = 0;
            for (int c = 0; c < 2; c++)
                hit_pre[c] = r_cs[c] && m_valid[c] && (r_addr[c] == m_tag[c]);
            chk("rnd_scr_ok", bus.scr_ok, hit_pre[0]);
            chk("rnd_obj_ok", bus.obj_ok, hit_pre[1]);
            if (was_cs && !bus.sdram_cs) begin
                chk("rnd_latency", cnt, (lat > 2) ? lat : 2);
                m_valid[g_cli] = 1;
                m_tag[g_cli] = 14'(g_addr - base(g_cli));
                m_data[g_cli] = mem(g_addr);
                m_last = g_cli;
                done = 1; dcli = g_cli;
            end
            chk("rnd_scr_data", bus.scr_data, m_data[0]);
            chk("rnd_obj_data", bus.obj_data, m_data[1]);
            cli = -1;
            if (!was_cs && bus.sdram_cs) begin
                cli = (bus.sdram_addr >= 22'h2000) ? 1 : 0;
                if (pend_prev[0] && pend_prev[1]) expc = 1 - m_last;
                else if (pend_prev[0]) expc = 0;
                else if (pend_prev[1]) expc = 1;
                else expc = -1;
                chk("rnd_gnt_client", cli, expc);
                chk("rnd_gnt_addr", bus.sdram_addr, base(cli) + 22'(r_addr[cli]));
                g_cli = cli; g_addr = bus.sdram_addr; cnt = 1;
                lat = $urandom_range(1, 4);
            end else if (bus.sdram_cs) begin
                cnt++;
                chk("rnd_addr_hold", bus.sdram_addr, g_addr);
            end
            for (int c = 0; c < 2; c++) begin
                pend_now[c] = r_cs[c] && !hit_pre[c] && !(done && dcli == c);
                if (!pend_now[c] || cli == c) starve[c] = 0;
                else starve[c]++;
                if (starve[c] > max_starve) max_starve = starve[c];
                pend_prev[c] = pend_now[c];
            end
            if (bus.sdram_cs) begin
                bus.sdram_ok = (cnt >= lat);
                bus.sdram_data = bus.sdram_ok ? mem(bus.sdram_addr) : $urandom;
            end else begin
                bus.sdram_ok = 0;
                bus.sdram_data = $urandom;
            end
            was_cs = bus.sdram_cs;
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 7) == 0) r_cs[c] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0)
                    r_addr[c] = 14'($urandom_range(0, 3)) + ((c == 1) ? 14'h0040 : 14'h0010);
            end
            bus.scr_cs = r_cs[0]; bus.scr_addr = r_addr[0][12:0];
            bus.obj_cs = r_cs[1]; bus.obj_addr = r_addr[1];
        end
        chk("rnd_no_starvation", max_starve <= 20, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtkicker_gfx_arb.md
# jtkicker_gfx_arb

Two-client arbiter that shares one 32-bit SDRAM graphics read port between the scroll tile fetcher and the object (sprite) line fetcher. It sits between both video layers and the SDRAM controller slot. It keeps a one-entry address/data cache per client, so repeated addresses never reach SDRAM. Priority favours scroll, which has a hard 8-pixel deadline, but the arbiter alternates whenever both clients are waiting, so the object fetcher cannot starve.

## Interface
Parameters:
- SCR_AW, 13, scroll client address width (32-bit word address).
- OBJ_AW, 14, object client address width.
- SDRAM_AW, 22, SDRAM port address width.
- SCR_OFFSET, 22'h0, SDRAM base address of the scroll ROM.
- OBJ_OFFSET, 22'h2000, SDRAM base address of the object ROM.

Ports:
- rst  in  1  asynchronous, active-high reset.
- clk  in  1  clock; 48 MHz system clock.
- scr_cs  in  1  scroll request.
- scr_addr  in  SCR_AW  scroll word address.
- scr_data  out  32  scroll data.
- scr_ok  out  1  scr_data is valid for the current scr_addr.
- obj_cs, obj_addr (OBJ_AW), obj_data (32), obj_ok  same as the scroll client, for objects.
- sdram_cs  out  1  SDRAM request, held until accepted.
- sdram_addr  out  SDRAM_AW  SDRAM word address.
- sdram_data  in  32  SDRAM read data.
- sdram_ok  in  1  sdram_data is valid for the issued address.

## Operation
- Each client has a cache: tag (client AW bits), data (32 bits) and a valid bit.
- A client hits when cs=1, valid=1 and addr==tag.
- A client misses when cs=1 and it does not hit. A miss raises that client's pending request.
- State machine states: IDLE, WAIT_SCR, WAIT_OBJ.
- IDLE, one miss only: serve that client.
- IDLE, both clients miss: serve scroll, unless the last grant was scroll. In that case serve objects.
- last_grant reset value is OBJ.
- On grant:
  - Latch the client address into issue_addr.
  - sdram_addr <= OFFSET + zero-extended address, as SDRAM_AW-bit modular addition (wraps silently).
  - sdram_cs <= 1; move to WAIT_SCR or WAIT_OBJ.
- WAIT_x:
  - The first cycle after issue is a blanking cycle. sdram_ok is ignored there, because the SDRAM slot needs one cycle to drop a stale ok.
  - From the second cycle on, sdram_ok=1 completes the fetch: tag_x <= issue_addr, data_x <= sdram_data, valid_x <= 1, sdram_cs <= 0, last_grant <= x, state goes to IDLE.
- Client address change while its fetch is in flight: the fetch still completes and fills the cache with the old address. The client's ok stays low, and the new address misses afterwards.
- A client dropping cs mid-fetch does not abort the SDRAM transaction.
- The arbiter never has more than one outstanding SDRAM request.
- x_ok is registered: x_ok <= x_cs & valid_x & (x_addr == tag_x).
- x_data always drives data_x.

## Timing
- Reset values:
  - sdram_cs=0, sdram_addr=0.
  - scr_ok=0, obj_ok=0, scr_data=0, obj_data=0.
  - Valid bits 0, tags 0, state IDLE, last_grant OBJ.
- Reset mid-fetch: the state returns to IDLE and the caches are invalidated immediately.
- Miss to sdram_cs: a miss seen in IDLE at edge N gives sdram_cs=1 with a valid sdram_addr after edge N+1.
- sdram_ok to client ok: sdram_ok sampled at edge M fills the cache at M. x_ok rises after edge M+1 if the address is unchanged.
- Hit latency: one clk from an address match to x_ok=1.
- An address change drops x_ok after the next edge.
- Back-to-back requests: the next grant may be issued at the edge after completion (IDLE lasts one cycle). Minimum SDRAM cycle per request is therefore 3 clk plus the SDRAM latency.

## Test plan
- Scroll hit:
  - Stimulus: scr_cs=1, scr_addr=13'h0123; SDRAM answers sdram_ok two cycles after sdram_cs with data 32'hDEADBEEF.
  - Required response: sdram_addr=22'h000123 and scr_data=32'hDEADBEEF with scr_ok=1. Holding the address afterwards triggers no new sdram_cs.
- Object offset:
  - Stimulus: obj_addr=14'h3FFF.
  - Required response: sdram_addr=22'h5FFF.
  - Stimulus: OBJ_OFFSET=22'h3FFFFF, obj_addr=1.
  - Required response: sdram_addr wraps to 22'h000000.
- Contention:
  - Stimulus: both clients miss continuously with changing addresses.
  - Required response: grants alternate SCR, OBJ, SCR, OBJ; the first grant after reset is SCR.
- Stale ok:
  - Stimulus: hold sdram_ok=1 permanently.
  - Required response: the fetch does not complete on the blanking cycle; it completes on the following cycle.
- Address change mid-fetch:
  - Stimulus: scr_addr goes 5 → 6 while WAIT_SCR.
  - Required response: the cache is tagged 5, scr_ok stays 0, and a second fetch for 6 is issued.
- Reset mid-fetch:
  - Stimulus: assert rst during WAIT_OBJ.
  - Required response: sdram_cs=0 and obj_ok=0 immediately. After release, the same obj_addr refetches.
